clk_div_ctrl: RTL and testbench

Upstream configuration stage for clk_div; drives its i_div and i_div_tog inputs.
- Accepts divide-ratio change requests over a valid/ready handshake and clamps each ratio to a legal maximum.
- Presents the ratio on o_div, then flips o_div_tog one cycle later.
- Enforces a guard interval before accepting the next request, so clk_div always samples a stable ratio.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_ctrl_if.sv | 25 ++
 rtl/clk_div_hold_cnt.sv | 31 +++
 rtl/clk_div_ctrl.sv | 148 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div family: FSM states of the ratio
// controller and default widths/limits used by clk_div, its controller and
// the benches.
package clk_div_pkg;

  // Default ratio width and largest legal ratio.
  localparam int DIV_W_DEF   = 8;
  localparam int DIV_MAX_DEF = 15;

  // Width of the guard counter and of the toggle counter.
  localparam int HOLD_W = 8;

  // Controller sequence: wait for a request, present the ratio, flip the
  // toggle, then guard the ratio before the next request can be taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TOG  = 2'd2,
    ST_HOLD = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio-change request channel (valid/ready) between a requester and
// clk_div_ctrl. The master issues requests; clk_div_ctrl is the slave.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic             i_req_vld;
  logic             o_req_rdy;
  logic [DIV_W-1:0] i_req_div;

  modport master (
    output i_req_vld,
    output i_req_div,
    input  o_req_rdy
  );

  modport slave (
    input  i_req_vld,
    input  i_req_div,
    output o_req_rdy
  );

endinterface

// File: rtl/clk_div_hold_cnt.sv
// Loadable down-counter used as the guard timer after each toggle.
// Load has priority over decrement; the counter never wraps below zero
// because the controller only decrements while the zero flag is low.
module clk_div_hold_cnt
  import clk_div_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [HOLD_W-1:0] cnt_reg;

  // Counter register: load wins over decrement, decrement saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else if (i_load) begin
      cnt_reg <= i_load_val;
    end else if (i_dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - HOLD_W'(1);
    end
  end

  // Zero flag straight from the register so it is glitch-free for the FSM.
  assign o_zero = (cnt_reg == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Configuration stage in front of clk_div. Takes ratio-change requests on a
// valid/ready channel, clamps them to DIV_MAX, drives the new ratio on o_div
// and flips o_div_tog one cycle later, then holds the ratio for HOLD_CYC
// cycles so clk_div always samples a settled value.
//
// Optional build macro CLK_DIV_CTRL_RAMP_EN: when defined, each update moves
// o_div by one step toward the target and repeats the load/toggle/hold
// sequence until the target is reached (one toggle per step). When undefined,
// o_div jumps straight to the target with a single toggle.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DIV_MAX  = DIV_MAX_DEF,
  parameter int HOLD_CYC = 16
)(
  input  logic               i_clk,
  input  logic               i_rst,
  clk_div_ctrl_if.slave      req,
  output logic [DIV_W-1:0]   o_div,
  output logic               o_div_tog,
  output logic               o_busy,
  output logic               o_clamp,
  output logic [HOLD_W-1:0]  o_upd_cnt
);

  localparam logic [DIV_W-1:0]  DIV_MAX_V  = DIV_W'(DIV_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYC - 1);

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [DIV_W-1:0] tgt_reg;
  logic [DIV_W-1:0] req_tgt;
  logic [DIV_W-1:0] div_next;
  logic             req_clamp;
  logic             xfer;
  logic             rdy;
  logic             hold_load;
  logic             hold_dec;
  logic             hold_zero;
  logic             more_steps;

  // Ready is a pure decode of the state register, never of the inputs.
  assign rdy           = (state_reg == ST_IDLE);
  assign req.o_req_rdy = rdy;
  assign o_busy        = ~rdy;
  assign xfer          = req.i_req_vld & rdy;

  // Clamp the incoming ratio to the largest value clk_div supports.
  assign req_clamp = (req.i_req_div > DIV_MAX_V);
  assign req_tgt   = req_clamp ? DIV_MAX_V : req.i_req_div;

`ifdef CLK_DIV_CTRL_RAMP_EN
  // Ramp mode: move one step toward the captured target per LOAD.
  always_comb begin
    div_next = o_div;
    if (o_div < tgt_reg) begin
      div_next = o_div + DIV_W'(1);
    end else if (o_div > tgt_reg) begin
      div_next = o_div - DIV_W'(1);
    end
  end

  // Another load/toggle/hold round is needed until the target is reached.
  assign more_steps = (o_div != tgt_reg);
`else
  // Direct mode: the captured target is applied in a single step.
  always_comb begin
    div_next = tgt_reg;
  end

  assign more_steps = 1'b0;
`endif

  // Guard timer is armed at the toggle and counts down through HOLD.
  assign hold_load = (state_reg == ST_TOG);
  assign hold_dec  = (state_reg == ST_HOLD) & ~hold_zero;

  clk_div_hold_cnt u_hold_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (hold_load),
    .i_load_val (HOLD_LOAD),
    .i_dec      (hold_dec),
    .o_zero     (hold_zero)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode. A request equal to the current ratio is accepted but
  // dropped so that no needless toggle reaches clk_div.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (xfer && (req_tgt != o_div)) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_TOG;
      end
      ST_TOG: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_zero) begin
          state_next = more_steps ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture target on transfer, update ratio only in LOAD, flip
  // toggle and bump the update count only in TOG, pulse clamp after transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tgt_reg   <= '0;
      o_div     <= '0;
      o_div_tog <= 1'b0;
      o_clamp   <= 1'b0;
      o_upd_cnt <= '0;
    end else begin
      o_clamp <= xfer & req_clamp;
      if (xfer) begin
        tgt_reg <= req_tgt;
      end
      if (state_reg == ST_LOAD) begin
        o_div <= div_next;
      end
      if (state_reg == ST_TOG) begin
        o_div_tog <= ~o_div_tog;
        o_upd_cnt <= o_upd_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl. Each expected toggle (ratio and update
// count) is queued when a request is issued; a monitor pops and compares on
// every o_div_tog flip and checks toggle spacing.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  localparam int DIV_W    = DIV_W_DEF;
  localparam int DIV_MAX  = DIV_MAX_DEF;
  localparam int HOLD_CYC = 16;
  localparam int ROUND    = HOLD_CYC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) req_if ();

  logic [DIV_W-1:0] div;
  logic             tog;
  logic             busy;
  logic             clamp;
  logic [7:0]       upd;

  clk_div_ctrl #(
    .DIV_W    (DIV_W),
    .DIV_MAX  (DIV_MAX),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .req       (req_if),
    .o_div     (div),
    .o_div_tog (tog),
    .o_busy    (busy),
    .o_clamp   (clamp),
    .o_upd_cnt (upd)
  );

  typedef struct {
    int div;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_upd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue the toggles a move from 'from' to 'to' must produce.
  task automatic expect_move(input int from, input int to, output int steps);
    int v;
    v     = from;
    steps = 0;
`ifdef CLK_DIV_CTRL_RAMP_EN
    while (v != to) begin
      v       = (v < to) ? v + 1 : v - 1;
      exp_upd = (exp_upd + 1) % 256;
      q.push_back('{v, exp_upd});
      steps++;
    end
`else
    if (v != to) begin
      exp_upd = (exp_upd + 1) % 256;
      q.push_back('{to, exp_upd});
      steps = 1;
    end
`endif
  endtask

  // Issue one request; returns the cycle index of the transfer edge.
  task automatic do_req(input int d, output int xcyc);
    int budget;
    budget = 0;
    req_if.i_req_vld = 1'b1;
    req_if.i_req_div = DIV_W'(d);
    while (!req_if.o_req_rdy && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 1000) chk("req_wait_timeout", budget, 0);
    @(posedge clk); #1;
    xcyc = cyc;
    req_if.i_req_vld = 1'b0;
    $display("req div=%0d accepted at cycle %0d", d, xcyc);
  endtask

  // Count cycles until ready returns.
  task automatic wait_idle(output int n);
    n = 0;
    while (!req_if.o_req_rdy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("idle_wait_timeout", n, 0);
  endtask

  // Monitor: every toggle flip is matched against the next queued entry.
  int   last_tog = -1;
  logic prev_tog = 1'b0;
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (rst) begin
      prev_tog = tog;
      last_tog = -1;
    end else if (tog != prev_tog) begin
      prev_tog = tog;
      $display("toggle div=%0d upd_cnt=%0d at cycle %0d", div, upd, cyc);
      if (q.size() == 0) begin
        chk("unexpected_toggle", 1, 0);
      end else begin
        e = q.pop_front();
        chk("tog_div", int'(div), e.div);
        chk("tog_upd_cnt", int'(upd), e.cnt);
      end
      if (last_tog >= 0) chk("tog_gap_ge_min", int'((cyc - last_tog) >= ROUND), 1);
      last_tog = cyc;
    end
  end

  initial begin
    int c1, c2, k1, k2, n, first;
    req_if.i_req_vld = 1'b0;
    req_if.i_req_div = '0;

    // 1: reset for three cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_div", int'(div), 0);
    chk("rst_tog", int'(tog), 0);
    chk("rst_rdy", int'(req_if.o_req_rdy), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clamp", int'(clamp), 0);
    chk("rst_upd", int'(upd), 0);

    // 2: request 5, check exact timing of ratio and toggle
`ifdef CLK_DIV_CTRL_RAMP_EN
    first = 1;
`else
    first = 5;
`endif
    expect_move(0, 5, k1);
    do_req(5, c1);
    chk("t2_busy_after_xfer", int'(busy), 1);
    chk("t2_div_unchanged_at_N", int'(div), 0);
    @(posedge clk); #1;
    chk("t2_div_at_N1", int'(div), first);
    chk("t2_tog_at_N1", int'(tog), 0);
    @(posedge clk); #1;
    chk("t2_tog_at_N2", int'(tog), 1);
    wait_idle(n);
    chk("t2_rdy_low_cycles", n + 2, ROUND * k1);
    chk("t2_upd", int'(upd), exp_upd);

    // 3: request 20 is clamped to DIV_MAX
    expect_move(5, DIV_MAX, k1);
    do_req(20, c1);
    chk("t3_clamp_pulse", int'(clamp), 1);
    @(posedge clk); #1;
    chk("t3_clamp_one_cycle", int'(clamp), 0);
    wait_idle(n);
    chk("t3_div", int'(div), DIV_MAX);
    chk("t3_upd", int'(upd), exp_upd);

    // 4: request equal to current ratio is accepted and dropped
    do_req(15, c1);
    chk("t4_rdy_stays", int'(req_if.o_req_rdy), 1);
    chk("t4_no_clamp", int'(clamp), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_rdy_later", int'(req_if.o_req_rdy), 1);
    chk("t4_div", int'(div), DIV_MAX);
    chk("t4_upd", int'(upd), exp_upd);

    // 5: back-to-back; 9 waits on valid and goes in at the first IDLE edge
    expect_move(DIV_MAX, 3, k1);
    expect_move(3, 9, k2);
    do_req(3, c1);
    do_req(9, c2);
    chk("t5_first_idle_edge", c2 - c1, ROUND * k1 + 1);
    wait_idle(n);
    chk("t5_div", int'(div), 9);
    chk("t5_upd", int'(upd), exp_upd);

    // 6: reset in HOLD discards the rest of the update
`ifdef CLK_DIV_CTRL_RAMP_EN
    expect_move(9, 8, k1);
`else
    expect_move(9, 7, k1);
`endif
    do_req(7, c1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_in_hold", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_div", int'(div), 0);
    chk("t6_rst_tog", int'(tog), 0);
    chk("t6_rst_rdy", int'(req_if.o_req_rdy), 1);
    chk("t6_rst_upd", int'(upd), 0);
    exp_upd = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 7: 0 -> 4 (ramped: four toggles through 1,2,3,4)
    expect_move(0, 4, k1);
    do_req(4, c1);
    wait_idle(n);
    chk("t7_rdy_low_cycles", n, ROUND * k1);
    chk("t7_div", int'(div), 4);
    chk("t7_upd", int'(upd), exp_upd);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=finish (cycle)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
